seq: RTL and testbench
======================

// Module: seq
// PURPOSE
//  Synchronous 2-bit-symbol sequence detector. Each clk rising edge samples the symbol S={B,A}.
//  Z flags completion of the symbol pattern 2'b11 -> 2'b00 -> 2'b01 (three consecutive samples).
//  Stand-alone control leaf; output Z feeds downstream event/status logic.
// PARAMETERS
//  none. Pattern symbols are fixed constants in seq_pkg: SYM0=2'b11, SYM1=2'b00, SYM2=2'b01.
// PORTS
//  clk  input  1  rising-edge clock; the only clock
//  clr  input  1  asynchronous active-low reset (clr=0 resets immediately; release is synchronous-safe)
//  A    input  1  symbol LSB; synchronous to clk
//  B    input  1  symbol MSB; S={B,A}
//  Z    output 1  detection flag; registered Moore output by default
// BEHAVIOUR
//  - Reset (clr=0, async): state<=IDLE, Z=0. Assertion mid-sequence discards all partial progress.
//  - Default FSM is Moore with 4 states. One transition per posedge, evaluated on sampled S.
//    IDLE: S==11->G1; else IDLE
//    G1 (seen 11): S==00->G2; S==11->G1; else IDLE
//    G2 (seen 11,00): S==01->HIT; S==11->G1; else IDLE
//    HIT: S==11->G1; else IDLE
//  - Z=1 iff state==HIT. This is exactly one cycle, starting at the edge that samples the final 01.
//  - Latency: Z rises at the same posedge that samples the third symbol. It is visible after clock-to-Q.
//  - Overlap: a trailing 11 always restarts at G1. Back-to-back matches (11,00,01,11,00,01) give two Z pulses 3 cycles apart.
//  - No X propagation: an illegal or unused state encoding recovers to IDLE on the next edge with Z=0.
//  - Inputs are sampled only at posedge. Glitches between edges have no effect.
// CONFIGURATION
//  SEQ_MEALY_EN defined: Z is combinational, Z=(state==G2)&&(S==2'b01).
//    Z asserts in the same cycle the final symbol is presented, one cycle earlier than the Moore version.
//    Z may glitch with A/B.
//    HIT is still entered so that overlap handling is unchanged.
//  SEQ_MEALY_EN undefined (default): registered Moore Z as described in BEHAVIOUR.
// STRUCTURE
//  seq_pkg contents:
//    - state typedef: enum {IDLE,G1,G2,HIT}, 2-bit encoding
//    - symbol constants SYM0/SYM1/SYM2
//  Single module, no sub-modules; one always_ff holds the state register, one always_comb holds next-state and Z.
// TESTING
//  1) Reset: clr=0 with random A/B for 3 cycles -> Z=0 and state IDLE throughout. Then clr=1.
//  2) Basic hit: S=11,00,01 on consecutive edges -> Z=1 for exactly 1 cycle after the 3rd edge, then 0.
//  3) Stream {B,A} = 11 00 01 11 00 11 10 11 10 01 10 11 00 01 11 10 (one pair per cycle) -> Z pulses after pairs #3 and #14 only.
//  4) Restart: S=11,11,00,01 -> one Z pulse. S=11,00,00,01 -> no pulse.
//  5) Mid-sequence reset: S=11,00, then clr=0 between edges -> state IDLE immediately. After release, S=01 -> Z stays 0.
//  6) With SEQ_MEALY_EN: rerun test 3 -> Z high while pairs #3 and #14 are applied, i.e. one cycle earlier than the Moore pulses.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the seq pattern detector.
// The pattern is three consecutive 2-bit symbols {B,A}: SYM0, SYM1, SYM2.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      G1   = 2'b01,
      G2   = 2'b10,
      HIT  = 2'b11
   } state_t;

   localparam logic [1:0] SYM0 = 2'b11;
   localparam logic [1:0] SYM1 = 2'b00;
   localparam logic [1:0] SYM2 = 2'b01;

endpackage

// File: rtl/seq.sv
// Sequence detector for the symbol pattern 11 -> 00 -> 01 on S={B,A}, one sample per clk edge.
// Z is a registered Moore flag (state==HIT) unless SEQ_MEALY_EN is defined, which makes Z combinational.
module seq
   import seq_pkg::*;
(
   input  logic   clk,
   input  logic   clr,
   input  logic   A,
   input  logic   B,
   output logic   Z,
   output state_t dbg_state
);

   state_t     state;
   state_t     state_n;
   logic [1:0] s;

   assign s         = {B, A};
   assign dbg_state = state;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // A fresh SYM0 always restarts the match at G1, which gives overlap handling for free.
   always_comb begin
      state_n = IDLE;
      Z       = 1'b0;
      case (state)
         IDLE: begin
            if (s == SYM0) state_n = G1;
         end
         G1: begin
            if (s == SYM1)      state_n = G2;
            else if (s == SYM0) state_n = G1;
         end
         G2: begin
            if (s == SYM2)      state_n = HIT;
            else if (s == SYM0) state_n = G1;
         end
         HIT: begin
            if (s == SYM0) state_n = G1;
         end
         default: state_n = IDLE;
      endcase
`ifdef SEQ_MEALY_EN
      Z = (state == G2) && (s == SYM2);
`else
      Z = (state == HIT);
`endif
   end

endmodule

// File: tb/tb_seq.sv
// Self-checking bench for seq: directed pattern tests plus a randomized stream checked
// against a model that matches the last few sampled symbols against the pattern.
module tb_seq;
   import seq_pkg::*;

   logic   clk;
   logic   clr;
   logic   A;
   logic   B;
   logic   Z;
   state_t dbg_state;

   int n_checks;
   int n_pass;

   logic [1:0] sym_q[$];

   logic z_pre;
   logic z_post;

   seq dut (
      .clk       (clk),
      .clr       (clr),
      .A         (A),
      .B         (B),
      .Z         (Z),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic tail_is(input int k, input logic [1:0] sym);
      int n;
      n = sym_q.size();
      if (n < k) return 1'b0;
      return sym_q[n-k] == sym;
   endfunction

   function automatic logic exp_hit();
      return tail_is(3, 2'b11) && tail_is(2, 2'b00) && tail_is(1, 2'b01);
   endfunction

   function automatic state_t exp_state();
      if (tail_is(1, 2'b11)) return G1;
      if (exp_hit()) return HIT;
      if (tail_is(2, 2'b11) && tail_is(1, 2'b00)) return G2;
      return IDLE;
   endfunction

   function automatic logic exp_z(input logic [1:0] cur);
`ifdef SEQ_MEALY_EN
      return tail_is(2, 2'b11) && tail_is(1, 2'b00) && (cur == 2'b01);
`else
      return exp_hit() & (cur == cur);
`endif
   endfunction

   // Present one symbol between edges, check before and after the sampling edge.
   task automatic step(input logic [1:0] s);
      @(negedge clk);
      {B, A} = s;
      #1;
      z_pre = Z;
      check("z_pre_edge", {31'd0, Z}, {31'd0, exp_z(s)});
      @(posedge clk);
      if (clr) begin
         sym_q.push_back(s);
         if (sym_q.size() > 3) void'(sym_q.pop_front());
      end
      #1;
      z_post = Z;
      check("z_post_edge", {31'd0, Z}, {31'd0, exp_z(s)});
      check("state", {30'd0, dbg_state}, {30'd0, exp_state()});
   endtask

   // Assert clr asynchronously between edges and release it just after an edge.
   task automatic async_reset();
      @(negedge clk);
      #2;
      clr = 1'b0;
      #1;
      sym_q.delete();
      check("rst_state_now", {30'd0, dbg_state}, {30'd0, IDLE});
      check("rst_z_now", {31'd0, Z}, 32'd0);
      @(posedge clk);
      #1;
      clr = 1'b1;
   endtask

   logic [1:0]  stream [16];
   logic [15:0] mask_pre;
   logic [15:0] mask_post;
   int          pulses;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      clr      = 1'b0;
      A        = 1'b0;
      B        = 1'b0;
      stream = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b11, 2'b10, 2'b11,
                 2'b10, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10};

      // 1) reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         step(2'($urandom_range(0, 3)));
         check("reset_z", {31'd0, Z}, 32'd0);
         check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
      end
      @(posedge clk);
      #1;
      clr = 1'b1;

      // 2) basic hit
      step(2'b11);
      step(2'b00);
      step(2'b01);
`ifdef SEQ_MEALY_EN
      check("basic_hit_pre", {31'd0, z_pre}, 32'd1);
`else
      check("basic_hit_post", {31'd0, z_post}, 32'd1);
`endif
      step(2'b10);
      check("basic_hit_drop", {31'd0, z_post}, 32'd0);

      // 3) reference stream, pulses expected at pairs 3 and 14
      mask_pre  = '0;
      mask_post = '0;
      for (int i = 0; i < 16; i++) begin
         step(stream[i]);
         mask_pre[i]  = z_pre;
         mask_post[i] = z_post;
      end
`ifdef SEQ_MEALY_EN
      check("stream_mask_mealy", {16'd0, mask_pre}, 32'h0000_2004);
`else
      check("stream_mask_moore", {16'd0, mask_post}, 32'h0000_2004);
`endif

      // 4) restart handling
      step(2'b10);
      pulses = 0;
      step(2'b11); step(2'b11); step(2'b00); step(2'b01);
      pulses += int'(z_post);
      step(2'b10);
`ifdef SEQ_MEALY_EN
      pulses = 0;
      step(2'b11); step(2'b11); step(2'b00); step(2'b01);
      pulses += int'(z_pre);
      step(2'b10);
`endif
      check("restart_one_pulse", pulses, 1);
      pulses = 0;
      step(2'b11); pulses += int'(z_pre) + int'(z_post);
      step(2'b00); pulses += int'(z_pre) + int'(z_post);
      step(2'b00); pulses += int'(z_pre) + int'(z_post);
      step(2'b01); pulses += int'(z_pre) + int'(z_post);
      check("broken_no_pulse", pulses, 0);

      // 5) mid-sequence reset discards progress
      step(2'b11);
      step(2'b00);
      async_reset();
      step(2'b01);
      check("post_reset_no_hit", {31'd0, z_pre | z_post}, 32'd0);

      // randomized stream with occasional resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) < 3) async_reset();
         else step(2'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
